// File: rtl/bus_enable_sequencer.sv
// bus_enable_sequencer: drives the TB-side enable of a counting bus and plays
// back "ON cycles high, OFF cycles low, REPS times" commands.
// Optional returned-data checker compiled in with `define SEQ_DATA_CHECK_EN.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready=1
// ON    | enable high, counting down the ON length
// OFF   | enable low, counting down the OFF length
module bus_enable_sequencer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    parameter int REP_W  = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CNT_W-1:0]  cmd_on,
    input  logic [CNT_W-1:0]  cmd_off,
    input  logic [REP_W-1:0]  cmd_reps,
    output logic              enable,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [ERR_W-1:0]  err_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] on_len, on_len_nxt;
    logic [CNT_W-1:0] off_len, off_len_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
    logic             done_nxt;
    logic             end_rep;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // Next-state and counter update; counters load N-1 and advance at zero.
    always_comb begin
        state_nxt   = state;
        on_len_nxt  = on_len;
        off_len_nxt = off_len;
        cnt_nxt     = cnt;
        rep_cnt_nxt = rep_cnt;
        done_nxt    = 1'b0;
        end_rep     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    on_len_nxt  = cmd_on;
                    off_len_nxt = cmd_off;
                    rep_cnt_nxt = (cmd_reps == '0) ? REP_ONE : cmd_reps;
                    if (cmd_on != '0) begin
                        state_nxt = S_ON;
                        cnt_nxt   = cmd_on - CNT_ONE;
                    end else if (cmd_off != '0) begin
                        state_nxt = S_OFF;
                        cnt_nxt   = cmd_off - CNT_ONE;
                    end else begin
                        // empty command: complete immediately, enable never rises
                        done_nxt = 1'b1;
                    end
                end
            end
            S_ON: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else if (off_len != '0) begin
                    state_nxt = S_OFF;
                    cnt_nxt   = off_len - CNT_ONE;
                end else begin
                    end_rep = 1'b1;
                end
            end
            S_OFF: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else begin
                    end_rep = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (end_rep) begin
            if (rep_cnt > REP_ONE) begin
                rep_cnt_nxt = rep_cnt - REP_ONE;
                if (on_len != '0) begin
                    state_nxt = S_ON;
                    cnt_nxt   = on_len - CNT_ONE;
                end else begin
                    state_nxt = S_OFF;
                    cnt_nxt   = off_len - CNT_ONE;
                end
            end else begin
                rep_cnt_nxt = '0;
                state_nxt   = S_IDLE;
                done_nxt    = 1'b1;
            end
        end
    end

    // State, counters and registered enable/done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            on_len  <= '0;
            off_len <= '0;
            cnt     <= '0;
            rep_cnt <= '0;
            enable  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            on_len  <= on_len_nxt;
            off_len <= off_len_nxt;
            cnt     <= cnt_nxt;
            rep_cnt <= rep_cnt_nxt;
            enable  <= (state_nxt == S_ON);
            done    <= done_nxt;
        end
    end

`ifdef SEQ_DATA_CHECK_EN
    localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);
    localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);

    logic              en_d;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_exp;
    logic              armed;
    logic              bad;
    logic              mismatch_q;
    logic [ERR_W-1:0]  err_q;

    // The far end counts while enabled and clears otherwise; wrap is legal.
    assign data_exp = en_d ? (data_d + DATA_ONE) : '0;
    assign bad      = armed && (data != data_exp);

    // Checker arms once a cleared cycle has been seen, since bus data is
    // undefined until the far end is forced to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_d       <= 1'b0;
            data_d     <= '0;
            armed      <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            en_d       <= enable;
            data_d     <= data;
            armed      <= armed | ~en_d;
            mismatch_q <= bad;
            if (bad && (err_q != '1)) begin
                err_q <= err_q + ERR_ONE;
            end
        end
    end

    assign mismatch  = mismatch_q;
    assign err_count = err_q;
`else
    logic unused_data;

    assign unused_data = ^data;
    assign mismatch    = 1'b0;
    assign err_count   = '0;
`endif

endmodule

// File: doc/bus_enable_sequencer.md
Name: bus_enable_sequencer

Overview:
- Controller for the TB end of the myBus interface: drives `enable` and receives the 8-bit `data` produced by the counting DUT end.
- Plays back commands of the form "enable high for ON cycles, low for OFF cycles, repeated REPS times".
- Optionally checks every returned data word against the DUT rule: data <= enable ? data+1 : 0.
- Replaces hand-written `#delay` enable stimulus in tb_top-style benches with a synthesizable, reusable sequencer.

Parameters:
- DATA_W, 8: width of the bus data word.
- CNT_W, 16: width of the ON/OFF cycle counts.
- REP_W, 8: width of the repeat count.
- ERR_W, 8: width of the mismatch counter, which saturates.

Ports:
- clk  input  1  bus clock, the same clk that feeds the myBus instance.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_on  input  CNT_W  cycles with enable=1.
- cmd_off  input  CNT_W  cycles with enable=0.
- cmd_reps  input  REP_W  repetitions; 0 is treated as 1.
- enable  output  1  drives busIf.enable (TB modport output).
- data  input  DATA_W  from busIf.data (TB modport input).
- busy  output  1  a command is executing.
- done  output  1  one-cycle pulse when a command completes.
- mismatch  output  1  one-cycle pulse on a data check failure.
- err_count  output  ERR_W  saturating count of mismatches.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high: rst is sampled on the rising edge of clk.
  - Reset values: enable=0, cmd_ready=1 (combinational from IDLE), busy=0, done=0, mismatch=0, err_count=0, state=IDLE.
  - All counters and check registers are cleared by reset.
- FSM states: IDLE, ON, OFF.
  - IDLE:
    - cmd_ready=1.
    - On cmd_valid, latch on/off/reps, with reps=max(cmd_reps,1).
    - Next state is ON if on>0; else OFF if off>0.
    - If on=0 and off=0, stay IDLE and pulse done next cycle; enable is never asserted.
  - ON:
    - enable=1 for exactly `on` consecutive cycles.
    - Then go to OFF if off>0; else end the repetition.
  - OFF:
    - enable=0 for exactly `off` cycles, then end the repetition.
  - End of repetition: decrement the rep counter. If the result is nonzero, restart at ON (or OFF when on=0). Otherwise go to IDLE and pulse done for 1 cycle.
- enable is a registered output equal to (state==ON).
  - First enable=1 appears the cycle after the accepting edge.
  - Back-to-back repetitions with off=0 give continuous enable=1 with no gap.
- Command handshake:
  - cmd_ready=0 outside IDLE; cmd_valid is ignored while busy.
  - busy=1 in ON and OFF.
  - A new command may be accepted in the same cycle done is high (IDLE re-entered).
- Counter arithmetic: down-counters load N-1 and advance on reaching 0, so on=1 gives exactly one enable cycle.
- Reset mid-command: state goes to IDLE, enable=0 on the next edge, and the command is discarded with no done pulse.

Optional Feature:
SEQ_DATA_CHECK_EN
- Defined:
  - Each cycle, register en_d=enable and data_d=data.
  - Expected next data = en_d ? (data_d+1) mod 2^DATA_W : 0; wrap 255 -> 0 is legal.
  - The checker arms after the first edge where en_d=0, since DUT data is undefined until forced to 0.
  - When armed and data differs from the expected value: mismatch=1 for one cycle, err_count += 1, saturating at all-ones.
  - The checker runs in all states, including IDLE.
- Undefined: no check logic; mismatch=0 and err_count=0 constantly.

Test Plan:
- Reset, then cmd on=3, off=2, reps=1 -> enable high exactly 3 cycles starting 1 cycle after accept, low 2, done pulses once; busy high for 5 cycles.
- Replay tb_top-equivalent cmd on=2, off=1, reps=4 against dut with SEQ_DATA_CHECK_EN -> data sequence 0,1,2,0,1,2,... with enable pattern 1,1,0 repeated, err_count=0.
- cmd on=300, off=0, reps=1 with checker on -> data wraps 255->0 with no mismatch; done after 300 cycles.
- Force busIf.data to 0x55 for one cycle while enable=1 -> exactly one mismatch pulse, err_count=1. Force 300 errors -> err_count holds 255.
- cmd on=0, off=0, reps=0 -> enable never rises, done pulses 1 cycle after accept. cmd_valid held while busy is not accepted until IDLE.
- Assert rst at cycle 2 of an on=10 command -> enable=0 after the reset edge, no done pulse, err_count=0, cmd_ready=1.
